// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch front end. Issues one I-cache request at a
// time for a two-instruction packet (pc, pc+4). It holds the returned packet
// until downstream consumes it, then advances to pc+8 or to the predicted
// target. A backend flush redirects the pc at any time. Data still in flight
// when a flush arrives is marked for discard, so a stale packet is never
// presented.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        stall,
  input  logic        bpu_taken,
  input  logic [31:0] bpu_target,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ack,
  input  logic        icache_rdata_valid,
  input  logic [31:0] icache_rdata_1,
  input  logic [31:0] icache_rdata_2,
  output logic [31:0] pc_1_o,
  output logic [31:0] pc_2_o,
  output logic [31:0] inst_1_o,
  output logic [31:0] inst_2_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        discard_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] pc_1_q;
  logic [31:0] pc_2_q;
  logic [31:0] inst_1_q;
  logic [31:0] inst_2_q;

  // Redirect and sequential addresses. The 32-bit adders wrap modulo 2^32.
  // A flush target is forced to word alignment.
  logic [31:0] flush_pc_d;
  logic [31:0] pc_seq_d;
  logic [31:0] pc_plus4_d;

  assign flush_pc_d = {flush_target[31:2], 2'b00};
  assign pc_seq_d   = pc_q + 32'd8;
  assign pc_plus4_d = pc_q + 32'd4;

  // Fetch FSM. The same block registers the request strobe and the packet
  // outputs. Flush is checked first in every state because it outranks
  // stall, prediction and returning data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, the packet data included, gets a reset value.
      // The outputs then read as zero right after reset, not as X.
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      pc_1_q    <= '0;
      pc_2_q    <= '0;
      inst_1_q  <= '0;
      inst_2_q  <= '0;
    end else begin
      // NOTE: only non-blocking assignments here. Every branch then reads the
      // pre-edge values of pc_q and discard_q, whatever order the branch
      // assigns them in.
      case (state_q)
        S_IDLE: begin
          if (flush) pc_q <= flush_pc_d;
          valid_q <= 1'b0;
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end

        S_REQ: begin
          // The address is pc_q. A flush without ack re-targets the request
          // on the next cycle. A flush with ack lets the request go out and
          // marks its data for discard.
          if (flush) pc_q <= flush_pc_d;
          if (icache_ack) begin
            state_q   <= S_WAIT;
            req_q     <= 1'b0;
            discard_q <= flush;
          end
        end

        S_WAIT: begin
          if (flush) begin
            pc_q <= flush_pc_d;
            if (icache_rdata_valid) begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
              req_q     <= 1'b1;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (icache_rdata_valid) begin
            if (discard_q) begin
              // Stale response from before a redirect. pc_q already holds the
              // redirect address.
              discard_q <= 1'b0;
              state_q   <= S_REQ;
              req_q     <= 1'b1;
            end else begin
              pc_1_q   <= pc_q;
              pc_2_q   <= pc_plus4_d;
              inst_1_q <= icache_rdata_1;
              inst_2_q <= icache_rdata_2;
              valid_q  <= 1'b1;
              state_q  <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // The prediction is used only when the packet leaves this state.
          if (flush) begin
            pc_q    <= flush_pc_d;
            valid_q <= 1'b0;
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end else if (!stall) begin
            pc_q    <= bpu_taken ? bpu_target : pc_seq_d;
            valid_q <= 1'b0;
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign icache_req   = req_q;
  assign icache_addr  = pc_q;
  assign pc_1_o       = pc_1_q;
  assign pc_2_o       = pc_2_q;
  assign inst_1_o     = inst_1_q;
  assign inst_2_o     = inst_2_q;
  assign inst_valid_o = valid_q;

endmodule
